// File: rtl/oh_hshake_tx_pkg.sv
// oh_hshake_tx_pkg: shared state encoding and defaults for the handshake transmitter
package oh_hshake_tx_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;
    localparam int TMAX_DEF = 1000;
    // The unused encoding 3 behaves exactly like IDLE
    function automatic logic [1:0] st_decode(input logic [1:0] s);
        return (s == ST_REQ || s == ST_REL) ? s : ST_IDLE;
    endfunction
endpackage

// File: rtl/oh_hshake_tx_if.sv
// oh_hshake_tx_if: upstream valid/ready, remote req/ack and status signals of the transmitter
interface oh_hshake_tx_if #(parameter int DW = 32);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          tx_req;
    logic [DW-1:0] tx_data;
    logic          rx_ack;
    logic          done;
    logic          busy;
    logic          err;
    logic          err_clr;
    modport master (input in_valid, in_data, rx_ack, err_clr,
                    output in_ready, tx_req, tx_data, done, busy, err);
    modport slave (output in_valid, in_data, rx_ack, err_clr,
                   input in_ready, tx_req, tx_data, done, busy, err);
endinterface

// File: rtl/oh_hshake_sync.sv
// oh_hshake_sync: PS-stage single-bit synchronizer with synchronous active-low reset
module oh_hshake_sync #(
    parameter int PS = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic din,
    output logic dout
);
    (* ASYNC_REG = "TRUE" *) logic [PS-1:0] chain;
    // Shift the asynchronous input through the flop chain
    always_ff @(posedge clk) begin
        if (!nreset) chain <= '0;
        else chain <= {chain[PS-2:0], din};
    end
    assign dout = chain[PS-1];
endmodule

// File: rtl/oh_hshake_tx.sv
// oh_hshake_tx: source side of a 4-phase req/ack crossing with sticky phase timeout
module oh_hshake_tx
    import oh_hshake_tx_pkg::*;
#(
    parameter int DW   = 32,
    parameter int PS   = 2,
    parameter int TW   = 16,
    parameter int TMAX = TMAX_DEF
) (
    input logic clk,
    input logic nreset,
    oh_hshake_tx_if.master io
);
    logic [1:0]    state;
    logic [1:0]    st;
    logic [TW-1:0] cnt;
    logic [DW-1:0] data;
    logic          ack_s;
    logic          req;
    logic          dn;
    logic          er;
    logic          accept;
    logic          exit_c;
    logic          fire;

    oh_hshake_sync #(.PS(PS)) u_sync (
        .clk(clk),
        .nreset(nreset),
        .din(io.rx_ack),
        .dout(ack_s)
    );

    assign st     = st_decode(state);
    assign accept = (st == ST_IDLE) && !ack_s && io.in_valid;
    assign exit_c = (st == ST_REQ && ack_s) || (st == ST_REL && !ack_s);
    assign fire   = (st != ST_IDLE) && !exit_c && (cnt == TW'(TMAX - 1));

    // Handshake sequencing: accept, raise req, wait ack, drop req, wait ack release
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= ST_IDLE;
            req   <= 1'b0;
            data  <= '0;
            dn    <= 1'b0;
            cnt   <= '0;
        end else begin
            dn    <= 1'b0;
            state <= st;
            if (accept) begin
                data  <= io.in_data;
                req   <= 1'b1;
                cnt   <= '0;
                state <= ST_REQ;
            end else if (st == ST_REQ && ack_s) begin
                req   <= 1'b0;
                cnt   <= '0;
                state <= ST_REL;
            end else if (st == ST_REL && !ack_s) begin
                dn    <= 1'b1;
                cnt   <= '0;
                state <= ST_IDLE;
            end else if (st != ST_IDLE) begin
                cnt <= (&cnt) ? cnt : cnt + 1'b1;
            end
        end
    end

    // Sticky timeout flag; a new timeout beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!nreset) er <= 1'b0;
        else er <= fire ? 1'b1 : (io.err_clr ? 1'b0 : er);
    end

    assign io.in_ready = (st == ST_IDLE) && !ack_s;
    assign io.busy     = (st != ST_IDLE);
    assign io.tx_req   = req;
    assign io.tx_data  = data;
    assign io.done     = dn;
    assign io.err      = er;
endmodule

// File: tb/tb_oh_hshake_tx.sv
// tb_oh_hshake_tx: directed and randomized checks of the handshake transmitter against a word-order model
module tb_oh_hshake_tx;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic auto_en = 1'b0;
    logic m_ack = 1'b0;
    logic a_ack;
    int   dly;
    int   total = 0;
    int   bad = 0;
    int   ndone = 0;
    int   spurious = 0;
    logic [31:0] exp_q[$];

    oh_hshake_tx_if #(.DW(32)) io ();

    oh_hshake_tx #(.DW(32), .PS(2), .TW(16), .TMAX(10)) dut (
        .clk(clk),
        .nreset(nreset),
        .io(io.master)
    );

    always #5 clk = ~clk;

    assign io.rx_ack = auto_en ? a_ack : m_ack;

    // Remote receiver: follows tx_req with a random 1..4 cycle lag
    always @(posedge clk) begin
        if (!auto_en) begin
            a_ack <= 1'b0;
            dly   <= 0;
        end else if (a_ack != io.tx_req) begin
            if (dly == 0) begin
                a_ack <= io.tx_req;
                dly   <= int'($urandom_range(3, 0));
            end else begin
                dly <= dly - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; every done pulse must deliver the oldest outstanding word
    task automatic step();
        @(posedge clk);
        #1;
        if (io.tx_req === 1'b1 && exp_q.size() > 0) chk("tx_data_held", io.tx_data, exp_q[0]);
        if (io.done === 1'b1) begin
            ndone++;
            if (exp_q.size() > 0) chk("done_data", io.tx_data, exp_q.pop_front());
            else spurious++;
        end
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        int to = 0;
        io.in_valid = 1'b1;
        io.in_data  = w;
        while (io.in_ready !== 1'b1 && to < 200) begin
            step();
            to++;
        end
        chk("send_wait", to < 200, 1);
        step();
        exp_q.push_back(w);
        io.in_valid = 1'b0;
        repeat (gap) begin
            io.in_data = $urandom;
            step();
        end
    endtask

    task automatic wait_idle();
        int to = 0;
        while ((exp_q.size() != 0 || io.busy !== 1'b0) && to < 400) begin
            step();
            to++;
        end
        chk("idle_wait", to < 400, 1);
    endtask

    task automatic wait_req_low();
        int to = 0;
        while (io.tx_req !== 1'b0 && to < 50) begin
            step();
            to++;
        end
        chk("req_low_wait", to < 50, 1);
    endtask

    task automatic manual_hs();
        m_ack = 1'b1;
        wait_req_low();
        m_ack = 1'b0;
        wait_idle();
    endtask

    initial begin
        int d0;
        io.in_valid = 1'b1;
        io.in_data  = 32'h1234_5678;
        io.err_clr  = 1'b0;
        m_ack       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_req", io.tx_req, 0);
            chk("rst_data", io.tx_data, 0);
            chk("rst_done", io.done, 0);
            chk("rst_err", io.err, 0);
        end
        io.in_valid = 1'b0;
        m_ack = 1'b0;
        nreset = 1'b1;
        step();
        chk("rst_ready", io.in_ready, 1);
        chk("rst_busy", io.busy, 0);

        io.in_valid = 1'b1;
        io.in_data  = 32'hDEAD_BEEF;
        chk("st_ready0", io.in_ready, 1);
        step();
        exp_q.push_back(32'hDEAD_BEEF);
        io.in_valid = 1'b0;
        io.in_data  = 32'h0BAD_F00D;
        for (int c = 1; c <= 13; c++) begin
            chk("st_req", io.tx_req, (c >= 1 && c <= 6));
            chk("st_done", io.done, (c == 12));
            if (c <= 12) chk("st_data", io.tx_data, 32'hDEAD_BEEF);
            if (c == 4) m_ack = 1'b1;
            if (c == 9) m_ack = 1'b0;
            if (c < 13) step();
        end
        chk("st_err", io.err, 0);

        auto_en = 1'b1;
        d0 = ndone;
        for (int i = 1; i <= 4; i++) send(32'(i), 0);
        wait_idle();
        chk("b2b_count", ndone - d0, 4);
        auto_en = 1'b0;

        io.in_valid = 1'b1;
        io.in_data  = 32'hA5A5_0001;
        step();
        exp_q.push_back(32'hA5A5_0001);
        io.in_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            chk("to_req", io.tx_req, 1);
            chk("to_err", io.err, (c >= 11));
            step();
        end
        manual_hs();
        chk("to_sticky", io.err, 1);
        io.err_clr = 1'b1;
        step();
        io.err_clr = 1'b0;
        chk("to_clear", io.err, 0);

        io.in_valid = 1'b1;
        io.in_data  = 32'hC011_1DE0;
        step();
        exp_q.push_back(32'hC011_1DE0);
        io.in_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 10) begin
                chk("col_pre", io.err, 0);
                io.err_clr = 1'b1;
            end
            if (c == 11) begin
                chk("col_set_wins", io.err, 1);
                io.err_clr = 1'b0;
            end
            if (c < 11) step();
        end
        manual_hs();
        io.err_clr = 1'b1;
        step();
        io.err_clr = 1'b0;
        chk("col_clear", io.err, 0);

        m_ack = 1'b1;
        repeat (3) step();
        io.in_valid = 1'b1;
        io.in_data  = 32'h0000_0077;
        for (int i = 0; i < 4; i++) begin
            chk("stray_ready", io.in_ready, 0);
            chk("stray_busy", io.busy, 0);
            step();
        end
        chk("stray_err", io.err, 0);
        m_ack = 1'b0;
        send(32'h0000_0077, 0);
        manual_hs();

        send(32'h5EED_0001, 0);
        m_ack = 1'b1;
        wait_req_low();
        step();
        chk("rel_busy", io.busy, 1);
        nreset = 1'b0;
        d0 = ndone;
        step();
        void'(exp_q.pop_front());
        chk("mid_req", io.tx_req, 0);
        chk("mid_busy", io.busy, 0);
        chk("mid_data", io.tx_data, 0);
        chk("mid_done", ndone - d0, 0);
        nreset = 1'b1;
        m_ack = 1'b0;
        send(32'h5EED_0002, 0);
        manual_hs();
        chk("mid_after", ndone - d0, 1);

        auto_en = 1'b1;
        d0 = ndone;
        for (int i = 0; i < 20; i++) send($urandom, int'($urandom_range(4, 0)));
        wait_idle();
        chk("rand_count", ndone - d0, 20);
        chk("rand_err", io.err, 0);
        chk("spurious", spurious, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
